// File: rtl/alu_unit_if.sv
// Operand/result bundle between the execute-stage sequencer and the ALU.
// The driver of operands uses master; the ALU itself uses slave.
interface alu_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ALUsel;
  logic [4:0]       ALUop;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             sign;

  modport master (
    output a, b, ALUsel, ALUop,
    input  result, carry, zero, sign
  );

  modport slave (
    input  a, b, ALUsel, ALUop,
    output result, carry, zero, sign
  );
endinterface

// File: rtl/alu_unit.sv
// miniRISC execute-stage integer ALU: one-cycle registered result plus
// carry/zero/sign flags. ALUsel=0 is the address-add path, ALUsel=1 decodes ALUop.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_unit_if.slave   alu_bus
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_COMP = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_NOT  = 5'd6,
    OP_SLL  = 5'd8,
    OP_SRL  = 5'd9,
    OP_SRA  = 5'd10,
    OP_DIFF = 5'd11
  } alu_op_e;

  // Index of the lowest set bit of x, or WIDTH when x is all zeros.
  function automatic logic [WIDTH-1:0] lowest_set(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] idx;
    idx = WIDTH'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i]) idx = WIDTH'(i);
    end
    return idx;
  endfunction

  logic [4:0]              shamt;
  logic [WIDTH:0]          sum_w;
  logic [WIDTH:0]          sub_w;
  logic [WIDTH:0]          sll_w;
  logic [WIDTH:0]          srl_w;
  logic signed [WIDTH:0]   sra_src;
  logic signed [WIDTH:0]   sra_w;
  logic [WIDTH-1:0]        diff_w;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d,  carry_q;
  logic             zero_d,   zero_q;
  logic             sign_d,   sign_q;

  assign shamt   = alu_bus.b[4:0];
  assign sum_w   = {1'b0, alu_bus.a} + {1'b0, alu_bus.b};
  assign sub_w   = {1'b0, alu_bus.a} - {1'b0, alu_bus.b};

  // Shifts run one bit wider so the last bit shifted out lands in the
  // extra position; a zero shift leaves that position clear.
  assign sll_w   = {1'b0, alu_bus.a} << shamt;
  assign srl_w   = {alu_bus.a, 1'b0} >> shamt;
  assign sra_src = {alu_bus.a, 1'b0};
  assign sra_w   = sra_src >>> shamt;
  assign diff_w  = lowest_set(alu_bus.a ^ alu_bus.b);

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    if (!alu_bus.ALUsel) begin
      {carry_d, result_d} = sum_w;
    end else begin
      case (alu_bus.ALUop)
        OP_ADD:  {carry_d, result_d} = sum_w;
        OP_SUB:  {carry_d, result_d} = sub_w;
        OP_COMP: result_d = -alu_bus.b;
        OP_AND:  result_d = alu_bus.a & alu_bus.b;
        OP_OR:   result_d = alu_bus.a | alu_bus.b;
        OP_XOR:  result_d = alu_bus.a ^ alu_bus.b;
        OP_NOT:  result_d = ~alu_bus.a;
        OP_SLL:  {carry_d, result_d} = sll_w;
        OP_SRL:  {result_d, carry_d} = srl_w;
        OP_SRA:  {result_d, carry_d} = sra_w;
        OP_DIFF: result_d = diff_w;
        default: begin
          result_d = '0;
          carry_d  = 1'b0;
        end
      endcase
    end
    zero_d = (result_d == '0);
    sign_d = result_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
    end
  end

  assign alu_bus.result = result_q;
  assign alu_bus.carry  = carry_q;
  assign alu_bus.zero   = zero_q;
  assign alu_bus.sign   = sign_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: table of hand-computed results plus
// short sequences for asynchronous reset and output hold between edges.
module tb_alu_unit;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [4:0]  op;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        s;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vq[$];

  alu_unit_if bus ();

  alu_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .alu_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic sel, input logic [4:0] op,
                              input logic [31:0] res, input logic c,
                              input logic z, input logic s);
    vec_t v;
    v.a = a; v.b = b; v.sel = sel; v.op = op;
    v.res = res; v.c = c; v.z = z; v.s = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] res,
                       input logic c, input logic z, input logic s);
    n_vec++;
    if (bus.result !== res || bus.carry !== c || bus.zero !== z || bus.sign !== s) begin
      n_bad++;
      $display("FAIL %s: got result=%h carry=%b zero=%b sign=%b, want result=%h carry=%b zero=%b sign=%b",
               name, bus.result, bus.carry, bus.zero, bus.sign, res, c, z, s);
    end else begin
      $display("ok   %s: result=%h carry=%b zero=%b sign=%b",
               name, bus.result, bus.carry, bus.zero, bus.sign);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic sel, input logic [4:0] op);
    bus.a = a; bus.b = b; bus.ALUsel = sel; bus.ALUop = op;
  endtask

  initial begin
    // a, b, ALUsel, ALUop, result, carry, zero, sign
    vq.push_back(mk(32'h8,        32'h9,        1'b0, 5'd1,  32'd17,       1'b0, 1'b0, 1'b0));
    vq.push_back(mk(32'h8,        32'h9,        1'b1, 5'd1,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b1));
    vq.push_back(mk(32'hFFFFFFFF, 32'h1,        1'b1, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0));
    vq.push_back(mk(32'h80000001, 32'h1,        1'b1, 5'd10, 32'hC0000000, 1'b1, 1'b0, 1'b1));
    vq.push_back(mk(32'h80000001, 32'h0,        1'b1, 5'd8,  32'h80000001, 1'b0, 1'b0, 1'b1));
    vq.push_back(mk(32'h10,       32'h30,       1'b1, 5'd11, 32'd5,        1'b0, 1'b0, 1'b0));
    vq.push_back(mk(32'h7,        32'h7,        1'b1, 5'd11, 32'd32,       1'b0, 1'b0, 1'b0));
    vq.push_back(mk(32'h5,        32'h1,        1'b1, 5'd2,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b1));
    vq.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd5,  32'hFFFFFFFE, 1'b1, 1'b0, 1'b1));
    vq.push_back(mk(32'h5,        32'h5,        1'b1, 5'd1,  32'h0,        1'b0, 1'b1, 1'b0));
    vq.push_back(mk(32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd3,  32'hF000F000, 1'b0, 1'b0, 1'b1));
    vq.push_back(mk(32'h0F0F0000, 32'h000000F0, 1'b1, 5'd4,  32'h0F0F00F0, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(32'hAAAA5555, 32'hFFFF0000, 1'b1, 5'd5,  32'h55555555, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(32'h0,        32'h1234,     1'b1, 5'd6,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b1));
    vq.push_back(mk(32'hFFFFFFFF, 32'h0,        1'b1, 5'd6,  32'h0,        1'b0, 1'b1, 1'b0));
    vq.push_back(mk(32'h80000001, 32'h1,        1'b1, 5'd8,  32'h2,        1'b1, 1'b0, 1'b0));
    vq.push_back(mk(32'h3,        32'h21,       1'b1, 5'd8,  32'h6,        1'b0, 1'b0, 1'b0));
    vq.push_back(mk(32'h80000003, 32'h1,        1'b1, 5'd9,  32'h40000001, 1'b1, 1'b0, 1'b0));
    vq.push_back(mk(32'h80000000, 32'd31,       1'b1, 5'd9,  32'h1,        1'b0, 1'b0, 1'b0));
    vq.push_back(mk(32'h80000000, 32'd31,       1'b1, 5'd10, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1));
    vq.push_back(mk(32'h40000000, 32'd4,        1'b1, 5'd10, 32'h04000000, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(32'h12345678, 32'h0,        1'b1, 5'd9,  32'h12345678, 1'b0, 1'b0, 1'b0));
    vq.push_back(mk(32'h5,        32'h5,        1'b1, 5'd7,  32'h0,        1'b0, 1'b1, 1'b0));
    vq.push_back(mk(32'h5,        32'h5,        1'b1, 5'd31, 32'h0,        1'b0, 1'b1, 1'b0));
    vq.push_back(mk(32'hFFFFFFFF, 32'h1,        1'b1, 5'd12, 32'h0,        1'b0, 1'b1, 1'b0));
    vq.push_back(mk(32'h9,        32'h0,        1'b1, 5'd2,  32'h0,        1'b0, 1'b1, 1'b0));
    vq.push_back(mk(32'h1,        32'd31,       1'b1, 5'd8,  32'h80000000, 1'b0, 1'b0, 1'b1));
    vq.push_back(mk(32'hFFFFFFFF, 32'd31,       1'b1, 5'd8,  32'h80000000, 1'b1, 1'b0, 1'b1));
    vq.push_back(mk(32'h0,        32'h80000000, 1'b1, 5'd11, 32'd31,       1'b0, 1'b0, 1'b0));
    vq.push_back(mk(32'h1,        32'h0,        1'b1, 5'd11, 32'd0,        1'b0, 1'b1, 1'b0));
    vq.push_back(mk(32'h7FFFFFFF, 32'h1,        1'b1, 5'd0,  32'h80000000, 1'b0, 1'b0, 1'b1));
    vq.push_back(mk(32'h0,        32'h1,        1'b1, 5'd1,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b1));
    vq.push_back(mk(32'h9,        32'h8,        1'b1, 5'd1,  32'h1,        1'b0, 1'b0, 1'b0));
    vq.push_back(mk(32'h80000001, 32'hFFFFFFE0, 1'b1, 5'd10, 32'h80000001, 1'b0, 1'b0, 1'b1));

    // Asynchronous reset: assert away from any clock edge with random operands.
    drive($urandom, $urandom, 1'b0, 5'($urandom_range(0, 31)));
    #2 rst_n = 1'b0;
    #1 check("reset_async", 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset held across an edge keeps outputs cleared.
    drive(32'h11, 32'h22, 1'b0, 5'd0);
    @(posedge clk); #1;
    check("reset_hold", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].a, vq[i].b, vq[i].sel, vq[i].op);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vq[i].res, vq[i].c, vq[i].z, vq[i].s);
    end

    // Outputs hold between edges even when inputs change; next edge updates.
    @(negedge clk);
    drive(32'h1, 32'h2, 1'b1, 5'd0);
    @(posedge clk); #1;
    check("hold_first", 32'h3, 1'b0, 1'b0, 1'b0);
    drive(32'h5, 32'h5, 1'b0, 5'd3);
    #2 check("hold_between", 32'h3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("hold_next", 32'hA, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation discards the registered result immediately.
    @(negedge clk);
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd0);
    @(posedge clk); #1;
    check("pre_midreset", 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("midreset", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    drive(32'h8, 32'h9, 1'b1, 5'd1);
    @(posedge clk); #1;
    check("post_reset", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
